// File: rtl/mux_scan_nx1_pkg.sv
// Shared encodings and helpers for the mux_scan_nx1 channel multiplexer.
package mux_scan_nx1_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_e;

    // LSB position of channel k in a packed bus of w-bit channels.
    function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/mux_scan_nx1_scan_seq.sv
// Scan sequencer: dwell counter, round-robin channel index and wrap detection.
// idx and wrap present the values that take effect at the coming edge.
module mux_scan_nx1_scan_seq #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DWELL = 4,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (en) begin
            // start also covers an abort on the same cycle as dwell expiry
            if (start) begin
                cnt_d = '0;
                idx_d = '0;
            end else if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_d;
    assign wrap = wrap_d;

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N-channel W-bit multiplexer with manual select and automatic
// round-robin scan mode.
module mux_scan_nx1
    import mux_scan_nx1_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned DWELL = 4,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] i_data,
    input  logic [N_CH-1:0]   i_valid,
    input  logic              en,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      y,
    output logic              y_valid,
    output logic [SEL_W-1:0]  y_ch,
    output logic              sel_err,
    output logic              scan_wrap
);

    localparam int unsigned N_SLOT = 2 ** SEL_W;
    localparam logic [SEL_W:0] N_CH_EXT = (SEL_W + 1)'(N_CH);

    // Pad to a power of two so any select value indexes a defined slot.
    logic [W-1:0]      ch_data [N_SLOT];
    logic [N_SLOT-1:0] vld_ext;

    for (genvar k = 0; k < N_SLOT; k++) begin : g_slot
        if (k < N_CH) begin : g_ch
            assign ch_data[k] = i_data[ch_lsb(k, W) +: W];
        end else begin : g_pad
            assign ch_data[k] = '0;
        end
    end

    assign vld_ext = N_SLOT'(i_valid);

    state_e           state_q, state_d;
    logic [W-1:0]     y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [SEL_W-1:0] y_ch_q, y_ch_d;
    logic             sel_err_q, sel_err_d;
    logic             scan_wrap_q, scan_wrap_d;

    logic             seq_start;
    logic [SEL_W-1:0] seq_idx;
    logic             seq_wrap;
    logic             sel_in_range;

    // Only an uninterrupted scan lets the sequencer advance; anything else rewinds it.
    assign seq_start    = !((state_q == ST_SCAN) && (mode == MODE_SCAN));
    assign sel_in_range = ({1'b0, sel} < N_CH_EXT);

    mux_scan_nx1_scan_seq #(
        .N_CH  (N_CH),
        .DWELL (DWELL)
    ) u_scan_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .start (seq_start),
        .idx   (seq_idx),
        .wrap  (seq_wrap)
    );

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        y_valid_d   = y_valid_q;
        y_ch_d      = y_ch_q;
        sel_err_d   = sel_err_q;
        scan_wrap_d = 1'b0;
        if (en) begin
            if (mode == MODE_SCAN) begin
                state_d     = ST_SCAN;
                y_d         = ch_data[seq_idx];
                y_valid_d   = vld_ext[seq_idx];
                y_ch_d      = seq_idx;
                sel_err_d   = 1'b0;
                scan_wrap_d = seq_wrap;
            end else begin
                state_d = ST_MANUAL;
                if (sel_in_range) begin
                    y_d       = ch_data[sel];
                    y_valid_d = vld_ext[sel];
                    y_ch_d    = sel;
                    sel_err_d = 1'b0;
                end else begin
                    y_d       = '0;
                    y_valid_d = 1'b0;
                    sel_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_MANUAL;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            y_ch_q      <= '0;
            sel_err_q   <= 1'b0;
            scan_wrap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            y_ch_q      <= y_ch_d;
            sel_err_q   <= sel_err_d;
            scan_wrap_q <= scan_wrap_d;
        end
    end

    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign y_ch      = y_ch_q;
    assign sel_err   = sel_err_q;
    assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Self-checking bench for mux_scan_nx1: a 4-channel/dwell-4 and a 3-channel/dwell-1
// instance, each compared every cycle against a position-based reference model.
module tb_mux_scan_nx1;

    localparam int unsigned NA = 4;
    localparam int unsigned DA = 4;
    localparam int unsigned NB = 3;
    localparam int unsigned DB = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] a_data;
    logic [3:0]  a_valid;
    logic        a_en, a_mode;
    logic [1:0]  a_sel;
    logic [7:0]  a_y;
    logic        a_yv, a_err, a_wrap;
    logic [1:0]  a_ych;

    logic [23:0] b_data;
    logic [2:0]  b_valid;
    logic        b_en, b_mode;
    logic [1:0]  b_sel;
    logic [7:0]  b_y;
    logic        b_yv, b_err, b_wrap;
    logic [1:0]  b_ych;

    mux_scan_nx1 #(.N_CH(NA), .W(8), .DWELL(DA)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_data    (a_data),
        .i_valid   (a_valid),
        .en        (a_en),
        .mode      (a_mode),
        .sel       (a_sel),
        .y         (a_y),
        .y_valid   (a_yv),
        .y_ch      (a_ych),
        .sel_err   (a_err),
        .scan_wrap (a_wrap)
    );

    mux_scan_nx1 #(.N_CH(NB), .W(8), .DWELL(DB)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_data    (b_data),
        .i_valid   (b_valid),
        .en        (b_en),
        .mode      (b_mode),
        .sel       (b_sel),
        .y         (b_y),
        .y_valid   (b_yv),
        .y_ch      (b_ych),
        .sel_err   (b_err),
        .scan_wrap (b_wrap)
    );

    // p counts enabled edges since scan entry; the channel shown is (p / DWELL) mod N.
    typedef struct {
        bit          in_scan;
        int unsigned p;
        logic [7:0]  y;
        bit          yv;
        int unsigned ych;
        bit          err;
        bit          wrap;
    } mdl_t;

    mdl_t ma, mb;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.in_scan = 0; s.p = 0; s.y = '0; s.yv = 0; s.ych = 0; s.err = 0; s.wrap = 0;
        return s;
    endfunction

    function automatic mdl_t mdl_next(mdl_t s, int unsigned n, int unsigned d,
                                      logic [31:0] data, logic [3:0] vld,
                                      bit en, bit mode, int unsigned sel);
        mdl_t r = s;
        r.wrap = 0;
        if (!en) return r;
        if (mode) begin
            r.p       = s.in_scan ? s.p + 1 : 0;
            r.in_scan = 1;
            r.ych     = (r.p / d) % n;
            r.y       = 8'(data >> (8 * r.ych));
            r.yv      = vld[r.ych];
            r.err     = 0;
            r.wrap    = (r.p != 0) && (r.p % (d * n) == 0);
        end else begin
            r.in_scan = 0;
            r.p       = 0;
            if (sel < n) begin
                r.y = 8'(data >> (8 * sel)); r.yv = vld[sel]; r.ych = sel; r.err = 0;
            end else begin
                r.y = '0; r.yv = 0; r.err = 1;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a_y",       32'(a_y),    32'(ma.y));
        check("a_y_valid", 32'(a_yv),   32'(ma.yv));
        check("a_y_ch",    32'(a_ych),  ma.ych);
        check("a_sel_err", 32'(a_err),  32'(ma.err));
        check("a_wrap",    32'(a_wrap), 32'(ma.wrap));
        check("b_y",       32'(b_y),    32'(mb.y));
        check("b_y_valid", 32'(b_yv),   32'(mb.yv));
        check("b_y_ch",    32'(b_ych),  mb.ych);
        check("b_sel_err", 32'(b_err),  32'(mb.err));
        check("b_wrap",    32'(b_wrap), 32'(mb.wrap));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            ma = mdl_reset();
            mb = mdl_reset();
        end else begin
            ma = mdl_next(ma, NA, DA, a_data, a_valid, a_en, a_mode, a_sel);
            mb = mdl_next(mb, NB, DB, {8'h00, b_data}, {1'b0, b_valid}, b_en, b_mode, b_sel);
        end
        #1;
        compare_all();
    endtask

    initial begin
        rst_n   = 1'b0;
        a_data  = 32'hD3C2B1A0; a_valid = 4'b1011; a_en = 1'b1; a_mode = 1'b0; a_sel = 2'd2;
        b_data  = 24'hC2B1A0;   b_valid = 3'b101;  b_en = 1'b1; b_mode = 1'b0; b_sel = 2'd1;
        ma = mdl_reset();
        mb = mdl_reset();

        repeat (3) tick();
        check("rst_y", 32'(a_y), 32'h0);
        check("rst_ych", 32'(a_ych), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        tick();
        check("man_y", 32'(a_y), 32'hC2);
        check("man_yv", 32'(a_yv), 32'h0);
        check("man_ych", 32'(a_ych), 32'h2);

        // Out-of-range select on the 3-channel instance
        b_sel = 2'd3;
        tick();
        check("oor_y", 32'(b_y), 32'h0);
        check("oor_ych", 32'(b_ych), 32'h1);
        check("oor_err", 32'(b_err), 32'h1);
        b_sel = 2'd0;
        tick();
        check("oor_clr", 32'(b_err), 32'h0);

        // Scan sequence through one full wrap
        a_mode = 1'b1;
        repeat (20) tick();

        // Freeze at channel 1, dwell count 2
        a_mode = 1'b0;
        tick();
        a_mode = 1'b1;
        repeat (7) tick();
        check("frz_pre_ch", 32'(a_ych), 32'h1);
        a_en = 1'b0;
        repeat (5) tick();
        check("frz_hold_ch", 32'(a_ych), 32'h1);
        a_en = 1'b1;
        repeat (4) tick();

        // Mode change on the edge that would wrap 3 -> 0
        a_mode = 1'b0;
        tick();
        a_mode = 1'b1;
        repeat (16) tick();
        check("exp_pre_ch", 32'(a_ych), 32'h3);
        a_mode = 1'b0;
        a_sel  = 2'd3;
        tick();
        check("chg_ch", 32'(a_ych), 32'h3);
        check("chg_wrap", 32'(a_wrap), 32'h0);
        a_mode = 1'b1;
        tick();
        check("reent_ch", 32'(a_ych), 32'h0);

        // Asynchronous reset between edges mid-scan
        repeat (8) tick();
        check("ar_pre_ch", 32'(a_ych), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("ar_y", 32'(a_y), 32'h0);
        check("ar_ych", 32'(a_ych), 32'h0);
        check("ar_yv", 32'(a_yv), 32'h0);
        ma = mdl_reset();
        mb = mdl_reset();
        #1 rst_n = 1'b1;
        tick();
        check("ar_rel_ch", 32'(a_ych), 32'h0);
        check("ar_rel_y", 32'(a_y), 32'hA0);

        // Randomized traffic on both instances
        b_mode = 1'b1;
        repeat (400) begin
            a_data  = $urandom;
            a_valid = 4'($urandom);
            a_en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) a_mode = ~a_mode;
            a_sel   = 2'($urandom);
            b_data  = 24'($urandom);
            b_valid = 3'($urandom);
            b_en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 11) == 0) b_mode = ~b_mode;
            b_sel   = 2'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
